register_file_mp: RTL and testbench

Parametrised multi-port register file: the next generation of the datapath 32x32 register file. It provides two combinational read ports, two clocked write ports with a fixed priority, optional write-to-read bypass, a per-register pending (scoreboard) bit, and a hardware bulk-clear sequencer. It sits between the decode stage (reads and pending checks) and writeback (two retiring results per cycle).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_fsm.sv | 52 +++++
 rtl/register_file_mp.sv | 105 ++++++++++
 tb/tb_register_file_mp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and clear-sequencer state type for the multi-port register file
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clrState_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - bulk-clear sequencer walking an index over every register
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              clear,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] clrIdx
);

   clrState_t         state;
   clrState_t         nextState;
   logic [ADDR_W-1:0] idx;

   // State register and index counter; the index restarts from 0 whenever idle
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= nextState;
         if (state == ST_CLEAR) begin
            idx <= idx + 1'b1;
         end else begin
            idx <= '0;
         end
      end
   end

   // Next state: leave CLEAR on the edge that clears the last register, so idx never wraps
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE:  if (clear) nextState = ST_CLEAR;
         ST_CLEAR: if (idx == {ADDR_W{1'b1}}) nextState = ST_DONE;
         ST_DONE:  nextState = ST_IDLE;
         default:  nextState = ST_IDLE;
      endcase
   end

   // Outputs decoded purely from the current state
   always_comb begin
      busy   = (state == ST_CLEAR);
      done   = (state == ST_DONE);
      clrIdx = idx;
   end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - two-read two-write register file with pending bits, bypass and bulk clear
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   output logic [DATA_W-1:0] BusA,
   output logic [DATA_W-1:0] BusB,
   output logic              PendA,
   output logic              PendB,
   input  logic [ADDR_W-1:0] RW0,
   input  logic [ADDR_W-1:0] RW1,
   input  logic [DATA_W-1:0] BusW0,
   input  logic [DATA_W-1:0] BusW1,
   input  logic              RegWr0,
   input  logic              RegWr1,
   input  logic              SetPend,
   input  logic [ADDR_W-1:0] PendAddr,
   input  logic              Clear,
   output logic              Busy,
   output logic              Done
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic [ADDR_W-1:0] clrIdx;
   logic              wr0Ok;
   logic              wr1Ok;
   logic              setOk;

   regfile_clear_fsm #(.ADDR_W(ADDR_W)) uClearFsm (
      .clk    (Clk),
      .rstN   (Reset_n),
      .clear  (Clear),
      .busy   (Busy),
      .done   (Done),
      .clrIdx (clrIdx)
   );

   // Qualify write and set requests: dropped while clearing, and reg 0 is untouchable when hardwired
   always_comb begin
      wr0Ok = RegWr0 && !Busy && !((ZERO_REG != 0) && (RW0 == '0));
      wr1Ok = RegWr1 && !Busy && !((ZERO_REG != 0) && (RW1 == '0));
      setOk = SetPend && !Busy && !((ZERO_REG != 0) && (PendAddr == '0));
   end

   // Data array: clear sequencer owns it while busy, otherwise port 1 is applied last so it wins
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (Busy) begin
         regs[clrIdx] <= '0;
      end else begin
         if (wr0Ok) regs[RW0] <= BusW0;
         if (wr1Ok) regs[RW1] <= BusW1;
      end
   end

   // Pending bits: writes retire a producer, a same-edge SetPend is applied last so the new producer wins
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pend <= '0;
      end else if (Busy) begin
         pend[clrIdx] <= 1'b0;
      end else begin
         if (wr0Ok) pend[RW0] <= 1'b0;
         if (wr1Ok) pend[RW1] <= 1'b0;
         if (setOk) pend[PendAddr] <= 1'b1;
      end
   end

   // Read port A with optional same-cycle bypass, port 1 taking priority over port 0
   always_comb begin
      BusA = regs[RA];
      if (BYPASS != 0) begin
         if (wr0Ok && (RW0 == RA)) BusA = BusW0;
         if (wr1Ok && (RW1 == RA)) BusA = BusW1;
      end
      if ((ZERO_REG != 0) && (RA == '0)) BusA = '0;
      PendA = pend[RA];
   end

   // Read port B, same selection rules as port A
   always_comb begin
      BusB = regs[RB];
      if (BYPASS != 0) begin
         if (wr0Ok && (RW0 == RB)) BusB = BusW0;
         if (wr1Ok && (RW1 == RB)) BusB = BusW1;
      end
      if ((ZERO_REG != 0) && (RB == '0)) BusB = '0;
      PendB = pend[RB];
   end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - directed self-checking bench for register_file_mp
module tb_register_file_mp;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [4:0]  RA, RB, RW0, RW1, PendAddr;
   logic [31:0] BusA, BusB, BusW0, BusW1;
   logic        PendA, PendB, RegWr0, RegWr1, SetPend, Clear, Busy, Done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  ra, rb, rw0;
      logic [31:0] w0;
      logic        we0;
      logic [4:0]  rw1;
      logic [31:0] w1;
      logic        we1;
      logic        sp;
      logic [4:0]  pa;
      logic [31:0] expA, expB;
      logic        expPA, expPB;
   } vec_t;

   vec_t vecs[$];

   register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
      .PendA(PendA), .PendB(PendB), .RW0(RW0), .RW1(RW1), .BusW0(BusW0), .BusW1(BusW1),
      .RegWr0(RegWr0), .RegWr1(RegWr1), .SetPend(SetPend), .PendAddr(PendAddr),
      .Clear(Clear), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      RW0 = '0; RW1 = '0; BusW0 = '0; BusW1 = '0;
      RegWr0 = 1'b0; RegWr1 = 1'b0; SetPend = 1'b0; PendAddr = '0; Clear = 1'b0;
   endtask

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   function automatic vec_t mk(input logic [4:0] ra, input logic [4:0] rb,
                               input logic [4:0] rw0, input logic [31:0] w0, input logic we0,
                               input logic [4:0] rw1, input logic [31:0] w1, input logic we1,
                               input logic sp, input logic [4:0] pa,
                               input logic [31:0] expA, input logic [31:0] expB,
                               input logic expPA, input logic expPB);
      vec_t v;
      v.ra = ra; v.rb = rb; v.rw0 = rw0; v.w0 = w0; v.we0 = we0;
      v.rw1 = rw1; v.w1 = w1; v.we1 = we1; v.sp = sp; v.pa = pa;
      v.expA = expA; v.expB = expB; v.expPA = expPA; v.expPB = expPB;
      return v;
   endfunction

   task automatic writeReg(input logic [4:0] a, input logic [31:0] d, input bit port1);
      idleInputs();
      if (port1) begin RW1 = a; BusW1 = d; RegWr1 = 1'b1; end
      else       begin RW0 = a; BusW0 = d; RegWr0 = 1'b1; end
      tick();
      idleInputs();
   endtask

   initial begin
      int busyCnt, doneCnt, doneAt, sawActivity;
      idleInputs();
      RA = '0; RB = '0;
      Reset_n = 1'b0;
      #1;
      check("reset_busy", {31'd0, Busy}, 32'd0);
      check("reset_done", {31'd0, Done}, 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // reset state across all addresses
      for (int i = 0; i < 32; i++) begin
         RA = 5'(i); RB = 5'(31 - i);
         #1;
         check("reset_busA", BusA, 32'd0);
         check("reset_busB", BusB, 32'd0);
         check("reset_pend", {30'd0, PendA, PendB}, 32'd0);
      end

      // fill through alternating ports; reg 0 gets a value that must be discarded
      for (int i = 0; i < 32; i++) begin
         writeReg(5'(i), (i == 0) ? 32'h12345678 : 32'(i), (i % 2) == 1);
      end
      for (int i = 0; i < 32; i++) begin
         RA = 5'(i); RB = 5'(i);
         #1;
         check("fill_busA", BusA, 32'(i));
         check("fill_busB", BusB, 32'(i));
      end

      // table of single-cycle vectors, checked before the edge they act on
      vecs.push_back(mk(5, 5, 5, 32'h0000AAAA, 1, 5, 32'h0000BBBB, 1, 0, 0, 32'h0000BBBB, 32'h0000BBBB, 0, 0));
      vecs.push_back(mk(5, 4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000BBBB, 32'd4, 0, 0));
      vecs.push_back(mk(7, 7, 0, 0, 0, 0, 0, 0, 1, 7, 32'd7, 32'd7, 0, 0));
      vecs.push_back(mk(7, 6, 0, 0, 0, 0, 0, 0, 0, 0, 32'd7, 32'd6, 1, 0));
      vecs.push_back(mk(7, 7, 7, 32'h77, 1, 0, 0, 0, 1, 7, 32'h77, 32'h77, 1, 1));
      vecs.push_back(mk(7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77, 32'h77, 1, 1));
      vecs.push_back(mk(7, 6, 0, 0, 0, 7, 32'h88, 1, 0, 0, 32'h88, 32'd6, 1, 0));
      vecs.push_back(mk(7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h88, 32'h88, 0, 0));
      vecs.push_back(mk(0, 1, 0, 32'hFFFF, 1, 0, 0, 0, 1, 0, 32'd0, 32'd1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd1, 0, 0));
      vecs.push_back(mk(9, 10, 9, 32'h99, 1, 10, 32'h1010, 1, 0, 0, 32'h99, 32'h1010, 0, 0));
      vecs.push_back(mk(9, 10, 0, 0, 0, 0, 0, 0, 1, 10, 32'h99, 32'h1010, 0, 0));
      vecs.push_back(mk(9, 10, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99, 32'h1010, 0, 1));

      foreach (vecs[n]) begin
         RA = vecs[n].ra; RB = vecs[n].rb;
         RW0 = vecs[n].rw0; BusW0 = vecs[n].w0; RegWr0 = vecs[n].we0;
         RW1 = vecs[n].rw1; BusW1 = vecs[n].w1; RegWr1 = vecs[n].we1;
         SetPend = vecs[n].sp; PendAddr = vecs[n].pa;
         #1;
         check($sformatf("vec%0d_busA", n), BusA, vecs[n].expA);
         check($sformatf("vec%0d_busB", n), BusB, vecs[n].expB);
         check($sformatf("vec%0d_pendA", n), {31'd0, PendA}, {31'd0, vecs[n].expPA});
         check($sformatf("vec%0d_pendB", n), {31'd0, PendB}, {31'd0, vecs[n].expPB});
         tick();
      end
      idleInputs();

      // bulk clear with a dropped write and SetPend in the middle
      for (int i = 1; i < 32; i++) writeReg(5'(i), 32'(i + 100), 1'b0);
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      busyCnt = 0; doneCnt = 0; doneAt = -1;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (Busy) busyCnt++;
         if (Done) begin doneCnt++; doneAt = c; end
         if (c == 10) begin
            RA = 5'd3; RW0 = 5'd3; BusW0 = 32'h3333; RegWr0 = 1'b1;
            SetPend = 1'b1; PendAddr = 5'd3;
            #1;
            check("busy_no_bypass", BusA, 32'd0);
         end
         tick();
         idleInputs();
      end
      check("clear_busy_cycles", 32'(busyCnt), 32'd32);
      check("clear_done_pulses", 32'(doneCnt), 32'd1);
      check("clear_done_cycle", 32'(doneAt), 32'd32);
      for (int i = 0; i < 32; i++) begin
         RA = 5'(i); RB = 5'(i);
         #1;
         check("cleared_busA", BusA, 32'd0);
         check("cleared_pend", {31'd0, PendA}, 32'd0);
      end

      // reset asserted in the middle of a clear
      writeReg(5'd31, 32'hDEAD, 1'b1);
      writeReg(5'd12, 32'hBEEF, 1'b0);
      SetPend = 1'b1; PendAddr = 5'd20;
      tick();
      idleInputs();
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      RA = 5'd31; RB = 5'd12;
      #1;
      check("midclear_busy", {31'd0, Busy}, 32'd1);
      check("midclear_reg31", BusA, 32'hDEAD);
      check("midclear_reg12", BusB, 32'hBEEF);
      Reset_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, Busy}, 32'd0);
      check("abort_reg31", BusA, 32'd0);
      check("abort_reg12", BusB, 32'd0);
      tick();
      Reset_n = 1'b1;
      sawActivity = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (Busy || Done) sawActivity++;
         tick();
      end
      check("abort_no_done", 32'(sawActivity), 32'd0);
      RA = 5'd20;
      #1;
      check("abort_pend20", {31'd0, PendA}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
